// File: rtl/ysyx_22040127_refill_arb_pkg.sv
// ============================================================================
// Module : ysyx_22040127_refill_arb_pkg
// Brief  : Shared state encodings and requester IDs for the refill arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`ifndef CACHE_DATA_SIZE
`define CACHE_DATA_SIZE 128
`endif
`default_nettype none

package ysyx_22040127_refill_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    // Requester IDs double as bit positions in the arbiter request/grant vectors
    localparam logic ID_IC = 1'b0;
    localparam logic ID_DC = 1'b1;

    localparam int C_LINE_W = `CACHE_DATA_SIZE;

endpackage

`default_nettype wire

// File: rtl/ysyx_22040127_refill_arb_if.sv
// ============================================================================
// Module : ysyx_22040127_refill_arb_if
// Brief  : Cache-side and memory-side handshake bundle of the refill arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`ifndef CACHE_DATA_SIZE
`define CACHE_DATA_SIZE 128
`endif
`default_nettype none

interface ysyx_22040127_refill_arb_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = `CACHE_DATA_SIZE
);
    logic                  ic_req_valid;
    logic [63:0]           ic_req_addr;
    logic                  ic_res_valid;
    logic [LINE_W-1:0]     ic_rdata;

    logic                  dc_req_valid;
    logic [63:0]           dc_req_addr;
    logic                  dc_req_wen;
    logic [LINE_W-1:0]     dc_req_wdata;
    logic [LINE_W/8-1:0]   dc_req_wstrb;
    logic                  dc_res_valid;
    logic [LINE_W-1:0]     dc_rdata;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_req_wen;
    logic [LINE_W-1:0]     mem_wdata;
    logic [LINE_W/8-1:0]   mem_wstrb;
    logic                  mem_res_valid;
    logic [LINE_W-1:0]     mem_rdata;

    // slave: the arbiter itself
    modport slave (
        input  ic_req_valid, ic_req_addr,
        input  dc_req_valid, dc_req_addr, dc_req_wen, dc_req_wdata, dc_req_wstrb,
        input  mem_req_ready, mem_res_valid, mem_rdata,
        output ic_res_valid, ic_rdata, dc_res_valid, dc_rdata,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_wdata, mem_wstrb
    );

    // master: caches plus memory bridge around the arbiter
    modport master (
        output ic_req_valid, ic_req_addr,
        output dc_req_valid, dc_req_addr, dc_req_wen, dc_req_wdata, dc_req_wstrb,
        output mem_req_ready, mem_res_valid, mem_rdata,
        input  ic_res_valid, ic_rdata, dc_res_valid, dc_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_wdata, mem_wstrb
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_22040127_rr_arb2.sv
// ============================================================================
// Module : ysyx_22040127_rr_arb2
// Brief  : Combinational two-way round-robin pick; ties go opposite to last.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_22040127_rr_arb2
    import ysyx_22040127_refill_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       any_valid
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == ID_DC) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign any_valid = |req;

endmodule

`default_nettype wire

// File: rtl/ysyx_22040127_refill_arb.sv
// ============================================================================
// Module : ysyx_22040127_refill_arb
// Brief  : Shares the single line-wide memory port between icache and dcache.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_22040127_refill_arb
    import ysyx_22040127_refill_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = C_LINE_W
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_22040127_refill_arb_if.slave    bus,
    output logic                         busy,
    output logic                         grant_dc,
    output logic                         err_stray
);

    arb_state_e            r_state;
    logic                  r_last;
    logic                  r_grant;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_wen;
    logic [LINE_W-1:0]     r_wdata;
    logic [LINE_W/8-1:0]   r_wstrb;
    logic [LINE_W-1:0]     r_line;
    logic                  r_ic_res;
    logic                  r_dc_res;
    logic                  r_err;

    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic                  w_any;
    logic [ADDR_W-1:0]     w_ic_line_addr;
    logic [ADDR_W-1:0]     w_dc_line_addr;
    logic                  w_unused_addr_bits;

    assign w_req = {bus.dc_req_valid, bus.ic_req_valid};

    ysyx_22040127_rr_arb2 u_rr_arb2 (
        .req       (w_req),
        .last      (r_last),
        .grant     (w_gnt),
        .any_valid (w_any)
    );

    // Line offset and bits above the memory address width are dropped
    assign w_ic_line_addr     = {bus.ic_req_addr[ADDR_W-1:4], 4'b0000};
    assign w_dc_line_addr     = {bus.dc_req_addr[ADDR_W-1:4], 4'b0000};
    assign w_unused_addr_bits = ^{bus.ic_req_addr[63:ADDR_W], bus.ic_req_addr[3:0],
                                  bus.dc_req_addr[63:ADDR_W], bus.dc_req_addr[3:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_last   <= ID_IC;
            r_grant  <= ID_IC;
            r_addr   <= '0;
            r_wen    <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_line   <= '0;
            r_ic_res <= 1'b0;
            r_dc_res <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ic_res <= 1'b0;
            r_dc_res <= 1'b0;
            if (bus.mem_res_valid && (r_state != WAIT)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= REQ;
                        if (w_gnt[ID_DC]) begin
                            r_grant <= ID_DC;
                            r_addr  <= w_dc_line_addr;
                            r_wen   <= bus.dc_req_wen;
                            r_wdata <= bus.dc_req_wdata;
                            r_wstrb <= bus.dc_req_wstrb;
                        end else if (w_gnt[ID_IC]) begin
                            r_grant <= ID_IC;
                            r_addr  <= w_ic_line_addr;
                            r_wen   <= 1'b0;
                            r_wdata <= '0;
                            r_wstrb <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_res_valid) begin
                        r_state  <= RESP;
                        r_line   <= bus.mem_rdata;
                        r_last   <= r_grant;
                        r_ic_res <= (r_grant == ID_IC);
                        r_dc_res <= (r_grant == ID_DC);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Memory request is decoded from state plus latched fields only
    assign bus.mem_req_valid = (r_state == REQ);
    assign bus.mem_req_addr  = r_addr;
    assign bus.mem_req_wen   = r_wen;
    assign bus.mem_wdata     = r_wdata;
    assign bus.mem_wstrb     = r_wstrb;

    assign bus.ic_res_valid  = r_ic_res;
    assign bus.dc_res_valid  = r_dc_res;
    assign bus.ic_rdata      = r_line;
    assign bus.dc_rdata      = r_line;

    assign busy      = (r_state != IDLE);
    assign grant_dc  = r_grant;
    assign err_stray = r_err;

endmodule

`default_nettype wire
